dca_lsu_inst_arbiter: RTL and testbench

- Shares one matrix-LSU instruction channel among NUM_REQ matrix-register-unit controllers. Each controller issues streams of block-level LSU read/write instructions.
- Round-robin arbitration. Once a requester wins, the grant is locked to it until it sends its beat flagged last, so a whole matrix transfer is never interleaved with another requester's.
- Records the requester ID of every accepted instruction in an in-order FIFO. LSU completion pulses are routed back to the owning requester.
- Sits between the MRU controllers and the single matrix LSU.

---
 rtl/dca_lsu_inst_arbiter_pkg.sv | 13 +
 rtl/dca_id_fifo.sv | 58 +++++
 rtl/dca_lsu_inst_arbiter.sv | 144 ++++++++++++++
 tb/tb_dca_lsu_inst_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dca_lsu_inst_arbiter_pkg.sv
// Shared types and helpers for the DCA matrix-LSU instruction arbiter.
package dca_lsu_inst_arbiter_pkg;

  typedef enum logic {
    StIdle   = 1'b0,
    StLocked = 1'b1
  } arb_state_e;

  function automatic int unsigned req_id_width(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/dca_id_fifo.sv
// In-order FIFO of small IDs; full/empty derive from the occupancy counter.
module dca_id_fifo #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == CntW'(Depth));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign rdata  = r_mem[r_rptr];
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
      if (w_push && !w_pop) begin
        r_count <= r_count + CntW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wdata;
  end

endmodule

// File: rtl/dca_lsu_inst_arbiter.sv
// Round-robin arbiter sharing one matrix-LSU instruction channel; a grant stays
// locked until the winner's last beat, and completions are routed back in order.
module dca_lsu_inst_arbiter
  import dca_lsu_inst_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 2,
  parameter int unsigned BW_INST         = 64,
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned BW_REQ_ID      = req_id_width(NUM_REQ),
  localparam int unsigned BW_CNT         = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       enable,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*BW_INST-1:0] req_inst,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       lsu_valid,
  output logic [BW_INST-1:0]         lsu_inst,
  input  logic                       lsu_ready,
  input  logic                       lsu_done,
  output logic [NUM_REQ-1:0]         done_list,
  output logic [BW_CNT-1:0]          outstanding,
  output logic                       busy,
  output logic                       error
);

  arb_state_e           r_state;
  logic [BW_REQ_ID-1:0] r_owner;
  logic [BW_REQ_ID-1:0] r_rr_ptr;
  logic                 r_error;

  logic                 w_active;
  logic [NUM_REQ-1:0]   w_rot;
  logic                 w_any;
  logic [BW_REQ_ID-1:0] w_rr_winner;
  logic [BW_REQ_ID-1:0] w_winner;
  logic                 w_has;
  logic                 w_win_valid;
  logic [BW_REQ_ID-1:0] w_next_rr;
  logic                 w_accept;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic [BW_REQ_ID-1:0] w_head;

  // Handshakes are suppressed while reset/clear is asserted so outputs read idle at once.
  assign w_active = enable & ~clear & ~rst;

  // Rotate valids so bit 0 is the requester at rr_ptr, then take the lowest set bit.
  always_comb begin
    w_rot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_rot[k] = req_valid[(int'(r_rr_ptr) + k) % NUM_REQ];
    end
  end

  always_comb begin
    w_any       = 1'b0;
    w_rr_winner = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_any       = 1'b1;
        w_rr_winner = BW_REQ_ID'((int'(r_rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    if (r_state == StLocked) begin
      w_winner    = r_owner;
      w_has       = 1'b1;
      w_win_valid = req_valid[r_owner];
    end else begin
      w_winner    = w_rr_winner;
      w_has       = w_any;
      w_win_valid = w_any;
    end
  end

  assign w_next_rr = (w_winner == BW_REQ_ID'(NUM_REQ - 1)) ? '0 : w_winner + BW_REQ_ID'(1);

  assign lsu_valid = w_active & w_win_valid & ~w_full;
  assign lsu_inst  = lsu_valid ? req_inst[w_winner*BW_INST +: BW_INST] : '0;
  assign w_accept  = lsu_valid & lsu_ready;
  assign w_pop     = w_active & lsu_done & ~w_empty;

  always_comb begin
    req_ready = '0;
    if (w_active && w_has && lsu_ready && !w_full) req_ready[w_winner] = 1'b1;
  end

  always_comb begin
    done_list = '0;
    if (w_pop) done_list[w_head] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_error  <= 1'b0;
    end else if (clear) begin
      r_state  <= StIdle;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_error  <= 1'b0;
    end else if (enable) begin
      if (w_accept) begin
        if (req_last[w_winner]) begin
          r_state  <= StIdle;
          r_rr_ptr <= w_next_rr;
        end else begin
          r_state <= StLocked;
          r_owner <= w_winner;
        end
      end
      if (lsu_done && w_empty) r_error <= 1'b1;
    end
  end

  dca_id_fifo #(
    .Width (BW_REQ_ID),
    .Depth (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (w_accept),
    .pop   (w_pop),
    .wdata (w_winner),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (outstanding)
  );

  assign busy  = (r_state == StLocked) | (outstanding != '0);
  assign error = r_error;

endmodule

// File: tb/tb_dca_lsu_inst_arbiter.sv
// Directed bench for dca_lsu_inst_arbiter with a queue-based reference model.
module tb_dca_lsu_inst_arbiter;

  localparam int N  = 2;
  localparam int BI = 64;
  localparam int MO = 4;

  logic          clk;
  logic          rst;
  logic          clear;
  logic          enable;
  logic [N-1:0]  req_valid;
  logic [N*BI-1:0] req_inst;
  logic [N-1:0]  req_last;
  logic [N-1:0]  req_ready;
  logic          lsu_valid;
  logic [BI-1:0] lsu_inst;
  logic          lsu_ready;
  logic          lsu_done;
  logic [N-1:0]  done_list;
  logic [2:0]    outstanding;
  logic          busy;
  logic          error;

  dca_lsu_inst_arbiter #(
    .NUM_REQ         (N),
    .BW_INST         (BI),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .enable      (enable),
    .req_valid   (req_valid),
    .req_inst    (req_inst),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .lsu_valid   (lsu_valid),
    .lsu_inst    (lsu_inst),
    .lsu_ready   (lsu_ready),
    .lsu_done    (lsu_done),
    .done_list   (done_list),
    .outstanding (outstanding),
    .busy        (busy),
    .error       (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of owner IDs plus lock/owner/round-robin bookkeeping.
  int q[$];
  int n_q[$];
  bit m_locked = 0, n_locked = 0;
  int m_owner = 0, n_owner = 0;
  int m_rr = 0, n_rr = 0;
  bit m_err = 0, n_err_m = 0;
  int acc_log[$];

  bit act, full, empty, has, wv, e_lv, acc, pop;
  int win;
  logic [63:0] e_inst;
  logic [N-1:0] e_rdy, e_done;

  always @(negedge clk) begin
    act   = enable && !clear && !rst;
    full  = (q.size() == MO);
    empty = (q.size() == 0);
    has = 0; wv = 0; win = 0;
    if (m_locked) begin
      win = m_owner; has = 1; wv = req_valid[m_owner];
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        if (req_valid[(m_rr + k) % N]) begin
          win = (m_rr + k) % N; has = 1; wv = 1;
        end
      end
    end
    e_lv   = act && wv && !full;
    e_inst = e_lv ? req_inst[win*BI +: BI] : 64'h0;
    e_rdy  = (act && has && lsu_ready && !full) ? N'(1 << win) : '0;
    acc    = e_lv && lsu_ready;
    pop    = act && lsu_done && !empty;
    e_done = pop ? N'(1 << q[0]) : '0;

    chk("lsu_valid", 64'(lsu_valid), 64'(e_lv));
    chk("lsu_inst", lsu_inst, e_inst);
    chk("req_ready", 64'(req_ready), 64'(e_rdy));
    chk("done_list", 64'(done_list), 64'(e_done));
    chk("outstanding", 64'(outstanding), 64'(q.size()));
    chk("busy", 64'(busy), 64'(m_locked || q.size() != 0));
    chk("error", 64'(error), 64'(m_err));

    if (lsu_valid && lsu_ready && req_ready != 0) acc_log.push_back(req_ready[1] ? 1 : 0);

    n_q = q; n_locked = m_locked; n_owner = m_owner; n_rr = m_rr; n_err_m = m_err;
    if (rst || clear) begin
      n_q.delete(); n_locked = 0; n_owner = 0; n_rr = 0; n_err_m = 0;
    end else if (enable) begin
      if (lsu_done) begin
        if (empty) n_err_m = 1;
        else void'(n_q.pop_front());
      end
      if (acc) begin
        n_q.push_back(win);
        if (req_last[win]) begin
          n_locked = 0; n_rr = (win + 1) % N;
        end else begin
          n_locked = 1; n_owner = win;
        end
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete(); m_locked <= 0; m_owner <= 0; m_rr <= 0; m_err <= 0;
    end else begin
      q = n_q; m_locked <= n_locked; m_owner <= n_owner; m_rr <= n_rr; m_err <= n_err_m;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_last = '0; lsu_done = 1'b0; clear = 1'b0; enable = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic drain();
    req_valid = '0;
    for (int i = 0; i < 20 && outstanding != 0; i++) begin
      lsu_done = 1'b1;
      tick();
    end
    lsu_done = 1'b0;
    #1;
    chk("drain", 64'(outstanding), 64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int b0, b1, n0, hold;
  bit held, f0, f1;
  logic [N-1:0] exp_done [3];

  initial begin
    rst = 1'b1; lsu_ready = 1'b1; req_inst = '0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_outstanding", 64'(outstanding), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    tick();

    // Single burst from req0
    for (int b = 0; b < 3; b++) begin
      req_valid = 2'b01;
      req_last  = (b == 2) ? 2'b01 : 2'b00;
      req_inst[63:0] = 64'hA0 + 64'(b);
      #1;
      chk("t1_ready", 64'(req_ready), 64'h1);
      chk("t1_inst", lsu_inst, 64'hA0 + 64'(b));
      tick();
    end
    req_valid = '0; req_last = '0;
    #1;
    chk("t1_outstanding", 64'(outstanding), 64'h3);
    for (int i = 0; i < 3; i++) begin
      lsu_done = 1'b1;
      #1;
      chk("t1_done", 64'(done_list), 64'h1);
      tick();
    end
    lsu_done = 1'b0;
    #1;
    chk("t1_empty", 64'(outstanding), 64'h0);

    // Lock and fairness
    do_reset();
    acc_log.delete();
    b0 = 0; b1 = 0; n0 = 0; hold = 0; held = 0;
    for (int c = 0; c < 40 && acc_log.size() < 6; c++) begin
      req_valid = {1'b1, hold == 0};
      req_last  = {b1 == 1, b0 == 1};
      req_inst  = {64'h100 + 64'(b1), 64'h200 + 64'(b0)};
      lsu_done  = (outstanding != 0);
      @(negedge clk);
      if (hold > 0) begin
        chk("t2_lock_ready1", 64'(req_ready[1]), 64'h0);
        chk("t2_lock_valid", 64'(lsu_valid), 64'h0);
      end
      f0 = req_valid[0] && req_ready[0];
      f1 = req_valid[1] && req_ready[1];
      tick();
      if (f0) begin b0 ^= 1; n0++; end
      if (f1) b1 ^= 1;
      if (hold > 0) hold--;
      else if (f0 && n0 == 1 && !held) begin hold = 2; held = 1; end
    end
    chk("t2_count", 64'(acc_log.size()), 64'h6);
    if (acc_log.size() == 6) begin
      chk("t2_g0", 64'(acc_log[0]), 64'h0);
      chk("t2_g1", 64'(acc_log[1]), 64'h0);
      chk("t2_g2", 64'(acc_log[2]), 64'h1);
      chk("t2_g3", 64'(acc_log[3]), 64'h1);
      chk("t2_g4", 64'(acc_log[4]), 64'h0);
      chk("t2_g5", 64'(acc_log[5]), 64'h0);
    end
    drain();

    // Backpressure when full
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_valid = 2'b01; req_last = 2'b01;
      #1;
      chk("t3_accept", 64'(lsu_valid), 64'h1);
      tick();
    end
    #1;
    chk("t3_full_block", 64'(lsu_valid), 64'h0);
    chk("t3_full_count", 64'(outstanding), 64'h4);
    lsu_done = 1'b1;
    #1;
    chk("t3_pop_block", 64'(lsu_valid), 64'h0);
    chk("t3_pop_done", 64'(done_list), 64'h1);
    tick();
    lsu_done = 1'b0;
    #1;
    chk("t3_after_pop", 64'(outstanding), 64'h3);
    chk("t3_resume", 64'(lsu_valid), 64'h1);
    tick();
    chk("t3_refill", 64'(outstanding), 64'h4);
    drain();

    // Completion routing and error
    do_reset();
    req_last = 2'b11;
    req_valid = 2'b10; tick();
    req_valid = 2'b01; tick();
    req_valid = 2'b10; tick();
    req_valid = 2'b00;
    #1;
    chk("t4_outstanding", 64'(outstanding), 64'h3);
    exp_done[0] = 2'b10; exp_done[1] = 2'b01; exp_done[2] = 2'b10;
    for (int i = 0; i < 3; i++) begin
      lsu_done = 1'b1;
      #1;
      chk("t4_route", 64'(done_list), 64'(exp_done[i]));
      tick();
    end
    chk("t4_no_err", 64'(error), 64'h0);
    #1;
    chk("t4_extra_done", 64'(done_list), 64'h0);
    tick();
    lsu_done = 1'b0;
    #1;
    chk("t4_error", 64'(error), 64'h1);

    // Asynchronous reset mid-transfer
    do_reset();
    req_valid = 2'b01; req_last = 2'b01; tick();
    req_valid = 2'b10; req_last = 2'b00; tick();
    req_valid = 2'b11;
    #1;
    chk("t5_pre_count", 64'(outstanding), 64'h2);
    chk("t5_pre_busy", 64'(busy), 64'h1);
    #1 rst = 1'b1;
    #1;
    chk("t5_rst_valid", 64'(lsu_valid), 64'h0);
    chk("t5_rst_count", 64'(outstanding), 64'h0);
    chk("t5_rst_busy", 64'(busy), 64'h0);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("t5_rst_rr0", 64'(req_ready), 64'h1);
    tick();

    // Synchronous clear mid-transfer
    do_reset();
    req_valid = 2'b01; req_last = 2'b01; tick();
    req_valid = 2'b10; req_last = 2'b00; tick();
    req_valid = 2'b11; clear = 1'b1;
    #1;
    chk("t5_clr_block", 64'(lsu_valid), 64'h0);
    chk("t5_clr_hold", 64'(outstanding), 64'h2);
    tick();
    clear = 1'b0;
    #1;
    chk("t5_clr_count", 64'(outstanding), 64'h0);
    chk("t5_clr_rr0", 64'(req_ready), 64'h1);
    chk("t5_clr_busy", 64'(busy), 64'h0);

    // Enable gating
    do_reset();
    enable = 1'b0; req_valid = 2'b01; req_last = 2'b01; lsu_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t6_gate_ready", 64'(req_ready), 64'h0);
      chk("t6_gate_valid", 64'(lsu_valid), 64'h0);
      tick();
    end
    chk("t6_gate_count", 64'(outstanding), 64'h0);
    enable = 1'b1;
    #1;
    chk("t6_en_valid", 64'(lsu_valid), 64'h1);
    chk("t6_en_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    #1;
    chk("t6_en_count", 64'(outstanding), 64'h1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
